// File: rtl/dist_fwd_scoreboard_if.sv
// Bundle between the ID/EX pipeline control and the distribution-register forwarding/hazard unit.
// The master drives the operand, stage and issue information; the slave returns forwarding and stall results.
interface dist_fwd_scoreboard_if #(
    parameter int NUM_SRC    = 2,
    parameter int ADDR_W     = 5,
    parameter int NUM_STAGES = 2,
    parameter int LAT_W      = 3,
    parameter int CNT_W      = 16
);
    logic [NUM_SRC*ADDR_W-1:0]     id_src_addr;
    logic [NUM_SRC-1:0]            id_src_valid;
    logic [NUM_STAGES-1:0]         stage_dreg_write;
    logic [NUM_STAGES*ADDR_W-1:0]  stage_dest_addr;
    logic                          issue_valid;
    logic [ADDR_W-1:0]             issue_dest_addr;
    logic [LAT_W-1:0]              issue_latency;
    logic                          flush;
    logic [NUM_SRC*NUM_STAGES-1:0] fwd_sel;
    logic                          stall;
    logic [(1<<ADDR_W)-1:0]        busy_vec;
    logic [CNT_W-1:0]              stall_cycles;

    modport master (
        output id_src_addr, id_src_valid, stage_dreg_write, stage_dest_addr,
        output issue_valid, issue_dest_addr, issue_latency, flush,
        input  fwd_sel, stall, busy_vec, stall_cycles
    );

    modport slave (
        input  id_src_addr, id_src_valid, stage_dreg_write, stage_dest_addr,
        input  issue_valid, issue_dest_addr, issue_latency, flush,
        output fwd_sel, stall, busy_vec, stall_cycles
    );
endinterface

// File: rtl/dist_fwd_scoreboard.sv
// Distribution-register forwarding with youngest-stage priority, plus a per-register
// countdown scoreboard that stalls ID while a multi-cycle result is still in flight.
module dist_fwd_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int ADDR_W     = 5,
    parameter int NUM_STAGES = 2,
    parameter int LAT_W      = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dist_fwd_scoreboard_if.slave  bus
);
    localparam int NUM_REGS = 1 << ADDR_W;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_SRC-1:0]  hz;
    logic                issue_multi;
    logic [CNT_W-1:0]    stall_cycles_q;
    logic [CNT_W-1:0]    stall_cycles_d;

    assign issue_multi = bus.issue_valid && (bus.issue_latency != '0);

    // One countdown per register; a new issue overwrites whatever was pending (newest op wins).
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [LAT_W-1:0] cnt_q;
        logic [LAT_W-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (bus.flush) begin
                cnt_d = '0;
            end else if (issue_multi && (bus.issue_dest_addr == ADDR_W'(gi))) begin
                cnt_d = bus.issue_latency;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign busy[gi] = (cnt_q != '0);
    end

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [ADDR_W-1:0]     src;
        logic [NUM_STAGES-1:0] sel;

        assign src    = bus.id_src_addr[gi*ADDR_W +: ADDR_W];
        assign hz[gi] = bus.id_src_valid[gi] &&
                        (busy[src] || (issue_multi && (bus.issue_dest_addr == src)));

        // Walk oldest to youngest so the youngest matching stage is the one left selected.
        always_comb begin
            sel = '0;
            for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                if (bus.stage_dreg_write[s] &&
                    (bus.stage_dest_addr[s*ADDR_W +: ADDR_W] == src)) begin
                    sel    = '0;
                    sel[s] = 1'b1;
                end
            end
            if (!bus.id_src_valid[gi] || hz[gi]) begin
                sel = '0;
            end
        end

        assign bus.fwd_sel[gi*NUM_STAGES +: NUM_STAGES] = sel;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((|hz) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall        = |hz;
    assign bus.busy_vec     = busy;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_dist_fwd_scoreboard.sv
// Directed bench: a table of combinational forwarding vectors plus hand-written scoreboard sequences.
module tb_dist_fwd_scoreboard;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dist_fwd_scoreboard_if #(.CNT_W(16)) dut_if ();
    dist_fwd_scoreboard_if #(.CNT_W(4))  sat_if ();

    dist_fwd_scoreboard #(.CNT_W(16)) u_dut (.clk(clk), .reset_n(reset_n), .bus(dut_if));
    dist_fwd_scoreboard #(.CNT_W(4))  u_sat (.clk(clk), .reset_n(reset_n), .bus(sat_if));

    typedef struct {
        logic [4:0] a0;
        logic [4:0] a1;
        logic [1:0] v;
        logic [1:0] wr;
        logic [4:0] d0;
        logic [4:0] d1;
        logic       iv;
        logic [4:0] id;
        logic [2:0] il;
        logic [3:0] ef;
        logic       es;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        dut_if.id_src_addr      = '0;
        dut_if.id_src_valid     = '0;
        dut_if.stage_dreg_write = '0;
        dut_if.stage_dest_addr  = '0;
        dut_if.issue_valid      = 1'b0;
        dut_if.issue_dest_addr  = '0;
        dut_if.issue_latency    = '0;
        dut_if.flush            = 1'b0;
    endtask

    task automatic issue(input logic [4:0] r, input logic [2:0] lat);
        dut_if.issue_valid     = 1'b1;
        dut_if.issue_dest_addr = r;
        dut_if.issue_latency   = lat;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        tick();
    endtask

    initial begin
        //            a0  a1  v      wr     d0  d1  iv  id  il  ef       es
        vecs[0] = '{5'd5, 5'd0, 2'b01, 2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 3'd0, 4'b0001, 1'b0};
        vecs[1] = '{5'd5, 5'd0, 2'b01, 2'b10, 5'd5, 5'd5, 1'b0, 5'd0, 3'd0, 4'b0010, 1'b0};
        vecs[2] = '{5'd3, 5'd7, 2'b11, 2'b11, 5'd3, 5'd7, 1'b0, 5'd0, 3'd0, 4'b1001, 1'b0};
        vecs[3] = '{5'd3, 5'd7, 2'b00, 2'b11, 5'd3, 5'd7, 1'b0, 5'd0, 3'd0, 4'b0000, 1'b0};
        vecs[4] = '{5'd0, 5'd0, 2'b01, 2'b01, 5'd0, 5'd9, 1'b0, 5'd0, 3'd0, 4'b0001, 1'b0};
        vecs[5] = '{5'd7, 5'd7, 2'b11, 2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 3'd0, 4'b0101, 1'b0};
        vecs[6] = '{5'd1, 5'd2, 2'b11, 2'b11, 5'd3, 5'd4, 1'b0, 5'd0, 3'd0, 4'b0000, 1'b0};
        vecs[7] = '{5'd4, 5'd0, 2'b01, 2'b01, 5'd4, 5'd0, 1'b1, 5'd4, 3'd0, 4'b0001, 1'b0};
        vecs[8] = '{5'd4, 5'd6, 2'b11, 2'b11, 5'd4, 5'd6, 1'b1, 5'd4, 3'd2, 4'b1000, 1'b1};

        idle();
        sat_if.id_src_addr      = '0;
        sat_if.id_src_valid     = '0;
        sat_if.stage_dreg_write = '0;
        sat_if.stage_dest_addr  = '0;
        sat_if.issue_valid      = 1'b0;
        sat_if.issue_dest_addr  = '0;
        sat_if.issue_latency    = '0;
        sat_if.flush            = 1'b0;

        #12 reset_n = 1'b1;
        tick();

        settle();
        chk("reset_busy", 64'(dut_if.busy_vec), 64'h0);
        chk("reset_stall_cycles", 64'(dut_if.stall_cycles), 64'h0);
        chk("reset_stall", 64'(dut_if.stall), 64'h0);
        chk("reset_fwd", 64'(dut_if.fwd_sel), 64'h0);
        tick();

        for (int i = 0; i < 9; i++) begin
            dut_if.id_src_addr      = {vecs[i].a1, vecs[i].a0};
            dut_if.id_src_valid     = vecs[i].v;
            dut_if.stage_dreg_write = vecs[i].wr;
            dut_if.stage_dest_addr  = {vecs[i].d1, vecs[i].d0};
            dut_if.issue_valid      = vecs[i].iv;
            dut_if.issue_dest_addr  = vecs[i].id;
            dut_if.issue_latency    = vecs[i].il;
            settle();
            chk($sformatf("vec%0d_fwd", i), 64'(dut_if.fwd_sel), 64'(vecs[i].ef));
            chk($sformatf("vec%0d_stall", i), 64'(dut_if.stall), 64'(vecs[i].es));
            tick();
        end
        idle();
        do_reset();

        // Multi-cycle op: r9 latency 3, src0 held on r9.
        dut_if.id_src_addr  = 10'd9;
        dut_if.id_src_valid = 2'b01;
        issue(5'd9, 3'd3);
        settle();
        chk("mc_issue_stall", 64'(dut_if.stall), 64'h1);
        chk("mc_issue_fwd", 64'(dut_if.fwd_sel), 64'h0);
        tick();
        dut_if.issue_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            settle();
            chk($sformatf("mc_stall_c%0d", c), 64'(dut_if.stall), 64'h1);
            chk($sformatf("mc_busy9_c%0d", c), 64'(dut_if.busy_vec[9]), 64'h1);
            tick();
        end
        dut_if.stage_dreg_write = 2'b01;
        dut_if.stage_dest_addr  = 10'd9;
        settle();
        chk("mc_done_stall", 64'(dut_if.stall), 64'h0);
        chk("mc_done_fwd", 64'(dut_if.fwd_sel), 64'h1);
        chk("mc_done_busy", 64'(dut_if.busy_vec), 64'h0);
        chk("mc_stall_cycles", 64'(dut_if.stall_cycles), 64'd4);
        tick();
        idle();

        // WAW overwrite on r2.
        issue(5'd2, 3'd5);
        tick();
        dut_if.issue_valid = 1'b0;
        settle();
        chk("waw_busy2_a", 64'(dut_if.busy_vec[2]), 64'h1);
        tick();
        issue(5'd2, 3'd1);
        tick();
        dut_if.issue_valid = 1'b0;
        settle();
        chk("waw_busy2_b", 64'(dut_if.busy_vec[2]), 64'h1);
        tick();
        settle();
        chk("waw_busy2_clear", 64'(dut_if.busy_vec), 64'h0);
        tick();

        // Other registers keep counting down while a new issue lands.
        issue(5'd6, 3'd2);
        tick();
        issue(5'd8, 3'd3);
        tick();
        dut_if.issue_valid = 1'b0;
        settle();
        chk("dec_busy_6_8", 64'(dut_if.busy_vec), 64'h140);
        tick();
        settle();
        chk("dec_busy_8_only", 64'(dut_if.busy_vec), 64'h100);
        tick();
        tick();

        // Flush wins over a same-cycle issue, and clears pending counts.
        issue(5'd4, 3'd7);
        dut_if.flush = 1'b1;
        tick();
        idle();
        settle();
        chk("flush_issue_busy", 64'(dut_if.busy_vec), 64'h0);
        tick();
        issue(5'd10, 3'd5);
        tick();
        idle();
        dut_if.flush = 1'b1;
        tick();
        dut_if.flush = 1'b0;
        settle();
        chk("flush_pending_busy", 64'(dut_if.busy_vec), 64'h0);
        tick();

        // Asynchronous reset mid-operation.
        issue(5'd1, 3'd6);
        tick();
        dut_if.issue_valid  = 1'b0;
        dut_if.id_src_addr  = 10'd1;
        dut_if.id_src_valid = 2'b01;
        settle();
        chk("ar_pre_stall", 64'(dut_if.stall), 64'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_busy", 64'(dut_if.busy_vec), 64'h0);
        chk("ar_stall_cycles", 64'(dut_if.stall_cycles), 64'h0);
        chk("ar_stall", 64'(dut_if.stall), 64'h0);
        reset_n = 1'b1;
        tick();
        idle();

        // Saturation on the 4-bit counter instance: stall held through a constant issue.
        sat_if.id_src_addr     = 10'd0;
        sat_if.id_src_valid    = 2'b01;
        sat_if.issue_valid     = 1'b1;
        sat_if.issue_dest_addr = 5'd0;
        sat_if.issue_latency   = 3'd1;
        settle();
        chk("sat_start", 64'(sat_if.stall_cycles), 64'h0);
        for (int c = 0; c < 14; c++) tick();
        settle();
        chk("sat_14", 64'(sat_if.stall_cycles), 64'd14);
        for (int c = 0; c < 6; c++) tick();
        settle();
        chk("sat_hold_15", 64'(sat_if.stall_cycles), 64'd15);
        sat_if.issue_valid  = 1'b0;
        sat_if.id_src_valid = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/dist_fwd_scoreboard.md
Name: dist_fwd_scoreboard

Overview:
- Parametrised distribution-register forwarding and hazard unit for the RV32I pipeline.
- Replaces the fixed two-stage, single-source distribution forwarding logic.
- Supports NUM_SRC source operands and NUM_STAGES forwarding stages with youngest-stage priority.
- Adds a per-register latency scoreboard for multi-cycle distribution ops: stalls ID until the result reaches the forwarding stages, and counts stall cycles for profiling.

Parameters:
- NUM_SRC, 2: distribution source operands read in ID.
- ADDR_W, 5: distribution register address width; 2**ADDR_W registers.
- NUM_STAGES, 2: forwarding stages; index 0 = youngest (EX), 1 = MEM, and so on.
- LAT_W, 3: width of the multi-cycle latency field and per-register countdown.
- CNT_W, 16: stall-cycle counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_src_addr  in  NUM_SRC*ADDR_W  ID source addresses; source i at bits [i*ADDR_W +: ADDR_W].
- id_src_valid  in  NUM_SRC  source i actually reads a distribution register.
- stage_dreg_write  in  NUM_STAGES  stage s writes a distribution register.
- stage_dest_addr  in  NUM_STAGES*ADDR_W  stage s destination address.
- issue_valid  in  1  EX issues a distribution op this cycle.
- issue_dest_addr  in  ADDR_W  destination of the issued op.
- issue_latency  in  LAT_W  extra cycles before the result enters stage 0 writeback; 0 = single-cycle op.
- flush  in  1  pipeline flush; cancels pending multi-cycle ops.
- fwd_sel  out  NUM_SRC*NUM_STAGES  one-hot forward select per source; all-zero = use register file.
- stall  out  1  hold ID/IF this cycle.
- busy_vec  out  2**ADDR_W  registers with a pending multi-cycle result.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- State:
  - cnt[r], LAT_W bits, one per register r.
  - busy_vec[r] = (cnt[r] != 0).
  - stall_cycles counter.
- Reset (reset_n low, asynchronous):
  - all cnt = 0, busy_vec = 0, stall_cycles = 0.
  - Effect is immediate, mid-operation included; pending ops are discarded.
  - stall and fwd_sel are combinational and follow inputs and the cleared state.
- Address 0 is an ordinary distribution register; it has no hardwired-zero exclusion.
- Forwarding (combinational, per source i):
  - Candidate stage s: stage_dreg_write[s] && stage_dest_addr[s] == src_i && id_src_valid[i].
  - fwd_sel picks the lowest-index candidate only.
  - Older stages writing the same address are suppressed (generalises the EX-over-MEM rule).
  - fwd_sel for source i is forced to zero when that source is the cause of stall.
- Hazard (combinational, per valid source i):
  - hz_i = busy_vec[src_i] || (issue_valid && issue_latency != 0 && issue_dest_addr == src_i).
  - stall = OR of all hz_i.
  - Registers not busy and not being issued never stall; single-cycle ops rely on forwarding.
- Scoreboard update (each edge, priority order):
  1. flush: all cnt = 0. Overrides a same-cycle issue.
  2. issue_valid && issue_latency != 0: cnt[issue_dest_addr] = issue_latency. Overwrites any pending count (WAW, newest op wins).
  3. otherwise, for every r with cnt[r] != 0: cnt[r] = cnt[r] - 1.
  - Issue to one register does not stop other registers decrementing that cycle.
  - issue_latency == 0 leaves the scoreboard unchanged.
- Countdown timing:
  - A register issued with latency L is busy for exactly L cycles after the issue edge.
  - On the cycle cnt reaches 0 the result is in stage 0 and is forwarded normally.
- stall_cycles:
  - increments on each edge where stall = 1.
  - saturates at 2**CNT_W-1; never wraps.
  - cleared only by reset, not by flush.
- No internal state depends on stall; the upstream pipeline is responsible for not re-issuing while stalled.

Test Plan:
- Single-cycle forward: stage0 writes r5, stage1 writes r5, src0 = r5 -> fwd_sel[src0] = 01 (stage 0 only); stage0 idle -> 10.
- Multi-source: src0 = r3, src1 = r7, stage1 writes r7, stage0 writes r3 -> src0 sel 01, src1 sel 10, stall = 0.
- Multi-cycle op: issue r9 latency 3, src0 = r9 held:
  - stall = 1 on the issue cycle and the following 3 cycles.
  - then stall = 0 with stage0 writing r9 -> fwd_sel 01.
  - stall_cycles = 4.
- WAW overwrite and flush:
  - issue r2 latency 5; 2 cycles later reissue r2 latency 1 -> busy_vec[2] clears 1 cycle later.
  - issue r4 latency 7 together with flush -> busy_vec[4] stays 0.
- Async reset mid-op: issue r1 latency 6, drop reset_n between edges -> busy_vec = 0 and stall_cycles = 0 immediately, stall = 0 with src0 = r1 and no issue.
- Saturation: CNT_W = 4, hold a stalling condition 20 cycles -> stall_cycles stops at 15.
